// File: rtl/ls161_pkg.sv
// Shared definitions for the LS161a interval-timer controller.
// State encodings and counter-width constants used by the FSM and its helpers.
package ls161_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    localparam int CNT_W_DEF = 4;

    // A PERIOD code of zero asks for the full 2^CNT_W counts.
    localparam logic [CNT_W_DEF-1:0] PERIOD_FULL = '0;

endpackage

// File: rtl/ls161_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones once reached until cleared.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         CLR_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!CLR_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ls161_timer_ctrl.sv
// One-shot / auto-reload interval timer controller driving a 4-bit LS161a counter.
// Presets the counter so its RCO fires after PERIOD counts, reports DONE and an expiry count.
module ls161_timer_ctrl
    import ls161_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int EXP_W = 8
) (
    input  logic             CLK,
    input  logic             CLR_n,
    input  logic             START,
    input  logic             STOP,
    input  logic             HOLD,
    input  logic             AUTO_RELOAD,
    input  logic [CNT_W-1:0] PERIOD,
    input  logic             RCO,
    output logic [CNT_W-1:0] D,
    output logic             LOAD_n,
    output logic             ENP,
    output logic             ENT,
    output logic             BUSY,
    output logic             DONE,
    output logic [EXP_W-1:0] EXP_CNT
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] period_r;
    logic             done_q;
    logic             capture;
    logic             expiry;

    // Counting up from -P reaches the all-ones carry state after exactly P counts.
    assign D    = '0 - period_r;
    assign DONE = done_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        expiry  = 1'b0;
        LOAD_n  = 1'b1;
        ENP     = 1'b0;
        ENT     = 1'b0;
        BUSY    = 1'b0;

        case (state_q)
            ST_LOAD: begin
                LOAD_n  = 1'b0;
                BUSY    = 1'b1;
                state_d = STOP ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                ENT  = 1'b1;
                ENP  = ~HOLD;
                BUSY = 1'b1;
                if (STOP) begin
                    state_d = ST_IDLE;
                end else if (RCO && !HOLD) begin
                    expiry  = 1'b1;
                    state_d = AUTO_RELOAD ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin  // ST_IDLE, and the unused 2'b11 code behaves the same
                if (START && !STOP) begin
                    capture = 1'b1;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!CLR_n) begin
            state_q  <= ST_IDLE;
            period_r <= CNT_W'(PERIOD_FULL);
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= expiry;
            if (capture) begin
                period_r <= PERIOD;
            end
        end
    end

    // Expiry count restarts on every accepted START.
    sat_counter #(
        .W (EXP_W)
    ) u_exp_cnt (
        .CLK   (CLK),
        .CLR_n (CLR_n),
        .clear (capture),
        .inc   (expiry),
        .count (EXP_CNT)
    );

endmodule

// File: tb/tb_ls161_timer_ctrl.sv
// Self-checking bench for ls161_timer_ctrl with a behavioural LS161a counter closing the loop.
// Table-driven vectors for the main sequences plus hand-written multi-cycle corner cases.
module tb_ls161_timer_ctrl;

    logic       CLK;
    logic       CLR_n;
    logic       START, STOP, HOLD, AUTO_RELOAD;
    logic [3:0] PERIOD;
    logic       RCO;
    logic [3:0] D;
    logic       LOAD_n, ENP, ENT, BUSY, DONE;
    logic [7:0] EXP_CNT;

    logic [3:0] q_m;
    logic       rco_inj;

    int n_checks = 0;
    int n_fail   = 0;

    ls161_timer_ctrl #(
        .CNT_W (4),
        .EXP_W (8)
    ) dut (
        .CLK         (CLK),
        .CLR_n       (CLR_n),
        .START       (START),
        .STOP        (STOP),
        .HOLD        (HOLD),
        .AUTO_RELOAD (AUTO_RELOAD),
        .PERIOD      (PERIOD),
        .RCO         (RCO),
        .D           (D),
        .LOAD_n      (LOAD_n),
        .ENP         (ENP),
        .ENT         (ENT),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .EXP_CNT     (EXP_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural LS161a: parallel load beats counting; RCO at Q=15 gated by ENT.
    always @(posedge CLK) begin
        if (!CLR_n)               q_m <= 4'h0;
        else if (!LOAD_n)         q_m <= D;
        else if (ENP && ENT)      q_m <= q_m + 4'h1;
    end
    assign RCO = ((q_m == 4'hF) && ENT) || rco_inj;

    typedef struct {
        logic       start, stop, hold, ar;
        logic [3:0] per;
        logic       inj;
        logic       load_n, enp, ent, busy, done;
        logic [3:0] d;
        logic [7:0] exp_cnt;
        logic       rco;
    } vec_t;

    localparam int N_VEC = 31;
    vec_t tbl [N_VEC];

    function automatic vec_t v(input logic st, input logic sp, input logic hd, input logic ar,
                               input logic [3:0] per, input logic inj,
                               input logic ln, input logic en_p, input logic en_t,
                               input logic bsy, input logic dn, input logic [3:0] d,
                               input logic [7:0] ec, input logic rc);
        vec_t r;
        r.start = st;  r.stop = sp;  r.hold = hd;  r.ar = ar;  r.per = per;  r.inj = inj;
        r.load_n = ln; r.enp = en_p; r.ent = en_t; r.busy = bsy; r.done = dn;
        r.d = d; r.exp_cnt = ec; r.rco = rc;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    task automatic half();
        @(negedge CLK);
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, ".load_n"},  LOAD_n,  1'b1);
        check({tag, ".enp"},     ENP,     1'b0);
        check({tag, ".ent"},     ENT,     1'b0);
        check({tag, ".busy"},    BUSY,    1'b0);
        check({tag, ".done"},    DONE,    1'b0);
        check({tag, ".d"},       D,       4'h0);
        check({tag, ".exp_cnt"}, EXP_CNT, 8'h00);
    endtask

    int  dones;
    bit  prev_done, dbl;

    initial begin
        // inputs:  st sp hd ar per  inj | ln enp ent bsy dn  d     exp  rco
        // one-shot P=5; START in RUN and a PERIOD change are ignored; RCO ignored in LOAD/IDLE
        tbl[0]  = v(1, 0, 0, 0, 4'd5, 0,   1, 0, 0, 0, 0, 4'h0, 8'd0, 0);
        tbl[1]  = v(0, 0, 0, 0, 4'd5, 1,   0, 0, 0, 1, 0, 4'hB, 8'd0, 1);
        tbl[2]  = v(0, 0, 0, 0, 4'd5, 0,   1, 1, 1, 1, 0, 4'hB, 8'd0, 0);
        tbl[3]  = v(1, 0, 0, 0, 4'd5, 0,   1, 1, 1, 1, 0, 4'hB, 8'd0, 0);
        tbl[4]  = v(0, 0, 0, 0, 4'd2, 0,   1, 1, 1, 1, 0, 4'hB, 8'd0, 0);
        tbl[5]  = v(0, 0, 0, 0, 4'd2, 0,   1, 1, 1, 1, 0, 4'hB, 8'd0, 0);
        tbl[6]  = v(0, 0, 0, 0, 4'd2, 0,   1, 1, 1, 1, 0, 4'hB, 8'd0, 1);
        tbl[7]  = v(0, 0, 0, 0, 4'd2, 0,   1, 0, 0, 0, 1, 4'hB, 8'd1, 0);
        tbl[8]  = v(0, 0, 0, 0, 4'd2, 1,   1, 0, 0, 0, 0, 4'hB, 8'd1, 1);
        tbl[9]  = v(0, 0, 0, 0, 4'd2, 0,   1, 0, 0, 0, 0, 4'hB, 8'd1, 0);
        // auto-reload P=3, PERIOD->9 mid-run, one HOLD cycle, then STOP on the RCO cycle
        tbl[10] = v(1, 0, 0, 1, 4'd3, 0,   1, 0, 0, 0, 0, 4'hB, 8'd1, 0);
        tbl[11] = v(0, 0, 0, 1, 4'd3, 0,   0, 0, 0, 1, 0, 4'hD, 8'd0, 0);
        tbl[12] = v(0, 0, 0, 1, 4'd9, 0,   1, 1, 1, 1, 0, 4'hD, 8'd0, 0);
        tbl[13] = v(0, 0, 0, 1, 4'd9, 0,   1, 1, 1, 1, 0, 4'hD, 8'd0, 0);
        tbl[14] = v(0, 0, 0, 1, 4'd9, 0,   1, 1, 1, 1, 0, 4'hD, 8'd0, 1);
        tbl[15] = v(0, 0, 0, 1, 4'd9, 0,   0, 0, 0, 1, 1, 4'hD, 8'd1, 0);
        tbl[16] = v(0, 0, 0, 1, 4'd9, 0,   1, 1, 1, 1, 0, 4'hD, 8'd1, 0);
        tbl[17] = v(0, 0, 0, 1, 4'd9, 0,   1, 1, 1, 1, 0, 4'hD, 8'd1, 0);
        tbl[18] = v(0, 0, 0, 1, 4'd9, 0,   1, 1, 1, 1, 0, 4'hD, 8'd1, 1);
        tbl[19] = v(0, 0, 0, 1, 4'd9, 0,   0, 0, 0, 1, 1, 4'hD, 8'd2, 0);
        tbl[20] = v(0, 0, 0, 1, 4'd9, 0,   1, 1, 1, 1, 0, 4'hD, 8'd2, 0);
        tbl[21] = v(0, 0, 1, 1, 4'd9, 0,   1, 0, 1, 1, 0, 4'hD, 8'd2, 0);
        tbl[22] = v(0, 0, 0, 1, 4'd9, 0,   1, 1, 1, 1, 0, 4'hD, 8'd2, 0);
        tbl[23] = v(0, 0, 0, 1, 4'd9, 0,   1, 1, 1, 1, 0, 4'hD, 8'd2, 1);
        tbl[24] = v(0, 0, 0, 1, 4'd9, 0,   0, 0, 0, 1, 1, 4'hD, 8'd3, 0);
        tbl[25] = v(0, 0, 0, 1, 4'd9, 0,   1, 1, 1, 1, 0, 4'hD, 8'd3, 0);
        tbl[26] = v(0, 0, 0, 1, 4'd9, 0,   1, 1, 1, 1, 0, 4'hD, 8'd3, 0);
        tbl[27] = v(0, 1, 0, 1, 4'd9, 0,   1, 1, 1, 1, 0, 4'hD, 8'd3, 1);
        tbl[28] = v(0, 0, 0, 0, 4'd9, 0,   1, 0, 0, 0, 0, 4'hD, 8'd3, 0);
        // STOP beats a simultaneous START: no capture, no clear
        tbl[29] = v(1, 1, 0, 0, 4'd9, 0,   1, 0, 0, 0, 0, 4'hD, 8'd3, 0);
        tbl[30] = v(0, 0, 0, 0, 4'd9, 0,   1, 0, 0, 0, 0, 4'hD, 8'd3, 0);

        CLR_n = 1'b0; START = 1'b0; STOP = 1'b0; HOLD = 1'b0;
        AUTO_RELOAD = 1'b0; PERIOD = 4'd0; rco_inj = 1'b0;
        adv();
        adv();
        half();
        check_idle_reset("reset");
        CLR_n = 1'b1;
        adv();

        for (int i = 0; i < N_VEC; i++) begin
            START = tbl[i].start; STOP = tbl[i].stop; HOLD = tbl[i].hold;
            AUTO_RELOAD = tbl[i].ar; PERIOD = tbl[i].per; rco_inj = tbl[i].inj;
            half();
            check($sformatf("vec%0d.load_n", i),  LOAD_n,  tbl[i].load_n);
            check($sformatf("vec%0d.enp", i),     ENP,     tbl[i].enp);
            check($sformatf("vec%0d.ent", i),     ENT,     tbl[i].ent);
            check($sformatf("vec%0d.busy", i),    BUSY,    tbl[i].busy);
            check($sformatf("vec%0d.done", i),    DONE,    tbl[i].done);
            check($sformatf("vec%0d.d", i),       D,       tbl[i].d);
            check($sformatf("vec%0d.exp_cnt", i), EXP_CNT, tbl[i].exp_cnt);
            check($sformatf("vec%0d.rco", i),     RCO,     tbl[i].rco);
            adv();
        end
        START = 1'b0; STOP = 1'b0; HOLD = 1'b0; rco_inj = 1'b0;

        // P=5 one-shot with HOLD for 3 cycles while Q=15: DONE moves from cycle 7 to cycle 10
        PERIOD = 4'd5; AUTO_RELOAD = 1'b0; START = 1'b1;
        adv();
        START = 1'b0;
        half();
        check("hold.load_n", LOAD_n, 1'b0);
        adv();
        repeat (4) adv();
        HOLD = 1'b1;
        for (int k = 0; k < 3; k++) begin
            half();
            check($sformatf("hold%0d.rco", k),  RCO,  1'b1);
            check($sformatf("hold%0d.enp", k),  ENP,  1'b0);
            check($sformatf("hold%0d.ent", k),  ENT,  1'b1);
            check($sformatf("hold%0d.done", k), DONE, 1'b0);
            adv();
        end
        HOLD = 1'b0;
        half();
        check("hold_rel.rco",  RCO,  1'b1);
        check("hold_rel.enp",  ENP,  1'b1);
        check("hold_rel.done", DONE, 1'b0);
        adv();
        half();
        check("hold_end.done", DONE, 1'b1);
        check("hold_end.busy", BUSY, 1'b0);
        check("hold_end.exp",  EXP_CNT, 8'd1);
        adv();

        // PERIOD=0 means 16 counts: preset 0, RCO on the 16th RUN cycle
        PERIOD = 4'd0; START = 1'b1;
        adv();
        START = 1'b0;
        half();
        check("p16.d",      D,      4'h0);
        check("p16.load_n", LOAD_n, 1'b0);
        for (int k = 0; k < 16; k++) begin
            adv();
            half();
            check($sformatf("p16_run%0d.busy", k), BUSY, 1'b1);
            check($sformatf("p16_run%0d.done", k), DONE, 1'b0);
            check($sformatf("p16_run%0d.rco", k),  RCO,  (k == 15));
        end
        adv();
        half();
        check("p16_end.done", DONE, 1'b1);
        check("p16_end.busy", BUSY, 1'b0);
        adv();

        // CLR_n on the would-be expiry edge: everything back to reset values
        PERIOD = 4'd5; START = 1'b1;
        adv();
        START = 1'b0;
        repeat (5) adv();
        half();
        check("clr.rco_before", RCO, 1'b1);
        CLR_n = 1'b0;
        adv();
        half();
        check_idle_reset("clr_mid_run");
        CLR_n = 1'b1;
        adv();

        // P=1 auto-reload for >300 expiries: EXP_CNT saturates, DONE never doubles
        PERIOD = 4'd1; AUTO_RELOAD = 1'b1; START = 1'b1;
        adv();
        START = 1'b0;
        dones = 0; prev_done = 1'b0; dbl = 1'b0;
        for (int k = 0; k < 620; k++) begin
            half();
            if (DONE === 1'b1) begin
                dones++;
                if (prev_done) dbl = 1'b1;
            end
            prev_done = (DONE === 1'b1);
            adv();
        end
        check("sat.enough_expiries", (dones >= 300), 1'b1);
        check("sat.no_double_done",  dbl,            1'b0);
        half();
        check("sat.exp_cnt", EXP_CNT, 8'd255);
        STOP = 1'b1;
        adv();
        STOP = 1'b0;
        AUTO_RELOAD = 1'b0;
        half();
        check("sat_stop.busy", BUSY,    1'b0);
        check("sat_stop.done", DONE,    1'b0);
        check("sat_stop.exp",  EXP_CNT, 8'd255);
        adv();
        START = 1'b1;
        adv();
        START = 1'b0;
        half();
        check("restart.exp",  EXP_CNT, 8'd0);
        check("restart.busy", BUSY,    1'b1);
        STOP = 1'b1;
        adv();
        STOP = 1'b0;
        adv();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
